multi_bank_fifo_ctrl: RTL and testbench
=======================================

Name: multi_bank_fifo_ctrl

Overview:
- Next-generation ping-pong controller. Generalises two-FIFO write/read steering to NUM_BANKS external FIFOs in a rotating ring.
- TDC samples fill one bank while filled banks drain to the SDK in order.
- Adds single-word and burst read modes, flush of a partial bank, overflow drop counting and a ready-bank count.
- Sits between the TDC output, NUM_BANKS external FIFO primitives (1-cycle read latency) and the SDK register interface.

Parameters:
DATA_W, 64, TDC/FIFO word width
NUM_BANKS, 4, number of external FIFOs; power of two, 2..16
BANK_W, $clog2(NUM_BANKS), bank index width (derived, not overridden)
CNT_W, 16, drop counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
done  in  1  TDC word valid, one pulse per word
datain_tdc  in  DATA_W  TDC word, valid with done
flush  in  1  pulse; close the current fill bank early
fifo_din  out  NUM_BANKS*DATA_W  per-bank write data; slice i = bank i
fifo_wr  out  NUM_BANKS  per-bank write enable
fifo_full  in  NUM_BANKS  per-bank full flag
fifo_empty  in  NUM_BANKS  per-bank empty flag
fifo_dout  in  NUM_BANKS*DATA_W  per-bank read data
fifo_rd  out  NUM_BANKS  per-bank read enable (combinational)
read_in  in  1  SDK read request (level; rising edge used)
burst_mode  in  1  0 = one word per edge, 1 = drain whole bank per edge
dataout_sdk  out  DATA_W  word to SDK
sdk_valid  out  1  dataout_sdk valid, one cycle
ready_cnt  out  BANK_W+1  banks in READY or DRAIN
wr_bank  out  BANK_W  current fill bank index
rd_bank  out  BANK_W  current drain bank index
overflow  out  1  sticky; a word was dropped
drop_cnt  out  CNT_W  dropped words, saturating

Behaviour:
- Per-bank state: FREE, FILL, READY, DRAIN.
- Reset:
  - bank0 = FILL, others FREE; wr_bank = rd_bank = 0.
  - All outputs 0; request/burst flags cleared.
- Write path:
  - done with a FILL bank present: registered next cycle, fifo_wr[wr_bank] = 1 and fifo_din slice = datain_tdc (1-cycle latency).
  - Non-selected slices drive 0.
- No FILL bank present: done is dropped. drop_cnt += 1 (saturates at all-ones); overflow = 1 until reset.
- Closing a fill bank:
  - Trigger: fifo_full[wr_bank] sampled high, or flush while the bank holds ≥1 word (flush ignored if !fifo_empty is false and no write is in flight).
  - Bank -> READY.
  - If bank (wr_bank+1) mod NUM_BANKS is FREE after this cycle's free update, it becomes FILL and wr_bank advances at the same edge. Otherwise there is no FILL bank until one frees; the freed bank becomes FILL the cycle after it goes FREE.
- A write registered in the closing cycle still completes to the old bank. External FIFO full blocks nothing further.
- Read request:
  - Rising edge = read_in_r1 & ~read_in_r2 (two-stage sampling, 2-cycle detect latency).
  - Edge with burst_mode = 0: sets req_pending.
  - Edge with burst_mode = 1: sets burst_active.
  - Edge while rd_bank is not READY/DRAIN: ignored; no queuing.
- fifo_rd[rd_bank] = (req_pending | burst_active) & ~fifo_empty[rd_bank] & (state READY or DRAIN). All other bits 0.
- A read pulse clears req_pending. The first read moves READY -> DRAIN.
- sdk_valid = registered fifo_rd OR-reduce; dataout_sdk = fifo_dout slice of the bank read, captured 1 cycle after fifo_rd.
- Draining a bank:
  - Bank in DRAIN with fifo_empty high and no fifo_rd this cycle -> FREE.
  - rd_bank advances mod NUM_BANKS; burst_active clears (a new edge is required per bank).
- Bank order: rd_bank always follows wr_bank order around the ring.
- ready_cnt is updated registered from the bank states.
- Simultaneous close on wr_bank and free on the bank ahead: resolved in one edge; the freed bank becomes FILL directly.
- Wrap: indices wrap NUM_BANKS-1 -> 0.
- Reset mid-burst: all state returns to reset values immediately; the external FIFOs must be reset by the system.

Test Plan:
- NUM_BANKS=4, depth 8: 8 done pulses, data 1..8; fifo_full[0] asserts -> bank0 READY, wr_bank=1, ready_cnt=1; fifo_wr[1] on the 9th word.
- burst_mode=1, read_in rising with bank0 holding 1..8 -> 8 consecutive fifo_rd[0]; sdk_valid words 1..8 in order; bank0 FREE; rd_bank=1; ready_cnt=0.
- burst_mode=0: three read_in edges -> exactly three sdk_valid pulses with words 1,2,3; bank0 stays DRAIN.
- Fill all 4 banks without reading, then 5 more done -> overflow=1, drop_cnt=5, no fifo_wr. Drain bank0 -> bank0 becomes FILL and wr_bank=0 the next cycle.
- 3 words to bank0, then flush -> bank0 READY, wr_bank=1. Burst read returns 3 words and bank0 frees.
- Assert reset during a burst at word 4 -> fifo_rd=0, sdk_valid=0, wr_bank=rd_bank=0, drop_cnt=0, overflow=0, ready_cnt=0 with no clock edge needed.

Source files
------------

// File: rtl/multi_bank_fifo_ctrl.sv
// Rotating multi-bank FIFO steering: TDC words fill one bank while closed
// banks drain to the SDK in ring order.
// state | meaning
// FREE  | bank empty and unassigned
// FILL  | bank receives TDC words
// READY | bank closed, waiting for its first read
// DRAIN | bank being read out
module multi_bank_fifo_ctrl #(
    parameter int DATA_W    = 64,
    parameter int NUM_BANKS = 4,
    parameter int CNT_W     = 16,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        done,
    input  logic [DATA_W-1:0]           datain_tdc,
    input  logic                        flush,
    output logic [NUM_BANKS*DATA_W-1:0] fifo_din,
    output logic [NUM_BANKS-1:0]        fifo_wr,
    input  logic [NUM_BANKS-1:0]        fifo_full,
    input  logic [NUM_BANKS-1:0]        fifo_empty,
    input  logic [NUM_BANKS*DATA_W-1:0] fifo_dout,
    output logic [NUM_BANKS-1:0]        fifo_rd,
    input  logic                        read_in,
    input  logic                        burst_mode,
    output logic [DATA_W-1:0]           dataout_sdk,
    output logic                        sdk_valid,
    output logic [BANK_W:0]             ready_cnt,
    output logic [BANK_W-1:0]           wr_bank,
    output logic [BANK_W-1:0]           rd_bank,
    output logic                        overflow,
    output logic [CNT_W-1:0]            drop_cnt
);

    typedef enum logic [1:0] {FREE, FILL, READY, DRAIN} bank_state_t;

    bank_state_t        st     [NUM_BANKS];
    bank_state_t        st_nxt [NUM_BANKS];
    logic [BANK_W-1:0]  wr_bank_nxt;
    logic [BANK_W-1:0]  nxt_bank;
    logic [BANK_W:0]    ready_nxt;

    logic               wr_q;
    logic [BANK_W-1:0]  wr_idx_q;
    logic [DATA_W-1:0]  din_q;
    logic               rd_q;
    logic [BANK_W-1:0]  rd_idx_q;

    logic               read_r1;
    logic               read_r2;
    logic               req_pending;
    logic               burst_active;

    logic               fill_here;
    logic               wr_accept;
    logic               drop;
    logic               inflight;
    logic               close;
    logic               bank_live;
    logic               rd_en;
    logic               free_now;
    logic               nxt_free;
    logic               rd_edge;

    always_comb begin
        fill_here = (st[wr_bank] == FILL);
        wr_accept = done & fill_here;
        drop      = done & ~fill_here;
        // a word registered last cycle is already committed to this bank
        inflight  = wr_q & (wr_idx_q == wr_bank);
        close     = fill_here &
                    (fifo_full[wr_bank] | (flush & (~fifo_empty[wr_bank] | inflight)));
        bank_live = (st[rd_bank] == READY) | (st[rd_bank] == DRAIN);
        rd_en     = (req_pending | burst_active) & ~fifo_empty[rd_bank] & bank_live;
        free_now  = (st[rd_bank] == DRAIN) & fifo_empty[rd_bank] & ~rd_en;
        nxt_bank  = wr_bank + 1'b1;
        nxt_free  = (st[nxt_bank] == FREE) | (free_now & (rd_bank == nxt_bank));
        rd_edge   = read_r1 & ~read_r2;
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            st_nxt[i] = st[i];
        end
        wr_bank_nxt = wr_bank;

        if (free_now) begin
            st_nxt[rd_bank] = FREE;
        end
        if (rd_en && (st[rd_bank] == READY)) begin
            st_nxt[rd_bank] = DRAIN;
        end

        if (close) begin
            st_nxt[wr_bank] = READY;
            if (nxt_free) begin
                st_nxt[nxt_bank] = FILL;
                wr_bank_nxt      = nxt_bank;
            end
        end else if (!fill_here && (st[nxt_bank] == FREE)) begin
            // waiting for the oldest bank: claim it the cycle after it frees
            st_nxt[nxt_bank] = FILL;
            wr_bank_nxt      = nxt_bank;
        end

        ready_nxt = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if ((st_nxt[i] == READY) || (st_nxt[i] == DRAIN)) begin
                ready_nxt = ready_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (i == 0) begin
                    st[i] <= FILL;
                end else begin
                    st[i] <= FREE;
                end
            end
            wr_bank      <= '0;
            rd_bank      <= '0;
            wr_q         <= 1'b0;
            wr_idx_q     <= '0;
            din_q        <= '0;
            rd_q         <= 1'b0;
            rd_idx_q     <= '0;
            read_r1      <= 1'b0;
            read_r2      <= 1'b0;
            req_pending  <= 1'b0;
            burst_active <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            ready_cnt    <= '0;
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                st[i] <= st_nxt[i];
            end
            wr_bank   <= wr_bank_nxt;
            ready_cnt <= ready_nxt;

            wr_q <= wr_accept;
            if (wr_accept) begin
                din_q    <= datain_tdc;
                wr_idx_q <= wr_bank;
            end

            rd_q <= rd_en;
            if (rd_en) begin
                rd_idx_q <= rd_bank;
            end

            read_r1 <= read_in;
            read_r2 <= read_r1;

            if (rd_en) begin
                req_pending <= 1'b0;
            end
            if (free_now) begin
                rd_bank      <= rd_bank + 1'b1;
                burst_active <= 1'b0;
            end
            // an edge landing on a bank that is just being released is dropped
            if (rd_edge && bank_live && !free_now) begin
                if (burst_mode) begin
                    burst_active <= 1'b1;
                end else begin
                    req_pending <= 1'b1;
                end
            end

            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        fifo_wr  = '0;
        fifo_din = '0;
        fifo_rd  = '0;
        if (wr_q) begin
            fifo_wr[wr_idx_q]                            = 1'b1;
            fifo_din[int'(wr_idx_q)*DATA_W +: DATA_W]    = din_q;
        end
        if (rd_en) begin
            fifo_rd[rd_bank] = 1'b1;
        end
    end

    // read data arrives one cycle after fifo_rd, aligned with sdk_valid
    assign sdk_valid   = rd_q;
    assign dataout_sdk = rd_q ? fifo_dout[int'(rd_idx_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_multi_bank_fifo_ctrl.sv
// Bench for multi_bank_fifo_ctrl: four depth-8 FIFO models, random TDC data,
// and a bank-queue reference model of the ring.
module tb_multi_bank_fifo_ctrl;

    localparam int DATA_W = 64;
    localparam int NB     = 4;
    localparam int BW     = 2;
    localparam int CNT_W  = 16;
    localparam int DEPTH  = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 done;
    logic [DATA_W-1:0]    datain_tdc;
    logic                 flush;
    logic [NB*DATA_W-1:0] fifo_din;
    logic [NB-1:0]        fifo_wr;
    logic [NB-1:0]        fifo_full;
    logic [NB-1:0]        fifo_empty;
    logic [NB*DATA_W-1:0] fifo_dout;
    logic [NB-1:0]        fifo_rd;
    logic                 read_in;
    logic                 burst_mode;
    logic [DATA_W-1:0]    dataout_sdk;
    logic                 sdk_valid;
    logic [BW:0]          ready_cnt;
    logic [BW-1:0]        wr_bank;
    logic [BW-1:0]        rd_bank;
    logic                 overflow;
    logic [CNT_W-1:0]     drop_cnt;

    multi_bank_fifo_ctrl #(.DATA_W(DATA_W), .NUM_BANKS(NB), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .done(done), .datain_tdc(datain_tdc), .flush(flush),
        .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_full(fifo_full),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
        .read_in(read_in), .burst_mode(burst_mode), .dataout_sdk(dataout_sdk),
        .sdk_valid(sdk_valid), .ready_cnt(ready_cnt), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // external FIFO primitives, 1-cycle read latency
    logic [DATA_W-1:0] mem [NB][DEPTH];
    logic [DATA_W-1:0] dout_m [NB];
    int                cnt [NB];
    int                wp [NB];
    int                rp [NB];
    logic [NB-1:0]     w_ok;
    logic [NB-1:0]     r_ok;

    always_comb begin
        w_ok       = '0;
        r_ok       = '0;
        fifo_full  = '0;
        fifo_empty = '0;
        fifo_dout  = '0;
        for (int b = 0; b < NB; b++) begin
            w_ok[b]                          = fifo_wr[b] && (cnt[b] < DEPTH);
            r_ok[b]                          = fifo_rd[b] && (cnt[b] > 0);
            fifo_full[b]                     = (cnt[b] == DEPTH);
            fifo_empty[b]                    = (cnt[b] == 0);
            fifo_dout[b*DATA_W +: DATA_W]    = dout_m[b];
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                cnt[b]    <= 0;
                wp[b]     <= 0;
                rp[b]     <= 0;
                dout_m[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (w_ok[b]) begin
                    mem[b][wp[b]] <= fifo_din[b*DATA_W +: DATA_W];
                    wp[b]         <= (wp[b] + 1) % DEPTH;
                end
                if (r_ok[b]) begin
                    dout_m[b] <= mem[b][rp[b]];
                    rp[b]     <= (rp[b] + 1) % DEPTH;
                end
                cnt[b] <= cnt[b] + int'(w_ok[b]) - int'(r_ok[b]);
            end
        end
    end

    // SDK-side monitor
    logic [DATA_W-1:0] got_q [$];
    int                rd_cnt [NB];

    always @(negedge clk) begin
        if (!reset) begin
            if (sdk_valid) got_q.push_back(dataout_sdk);
            for (int b = 0; b < NB; b++) begin
                if (fifo_rd[b]) rd_cnt[b] <= rd_cnt[b] + 1;
            end
        end
    end

    // reference model: words per bank, closed banks in ring order
    logic [DATA_W-1:0] m_q [NB][$];
    int                m_ready [$];
    int                m_fill;
    int                m_last;
    int                m_rd;
    int                m_drop;

    int tests  = 0;
    int failed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_is_free(input int b);
        if (b == m_fill) return 1'b0;
        foreach (m_ready[i]) if (m_ready[i] == b) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_close();
        int nb;
        m_ready.push_back(m_fill);
        m_last = m_fill;
        nb     = (m_fill + 1) % NB;
        m_fill = -1;
        if (m_is_free(nb)) m_fill = nb;
    endtask

    task automatic m_drained();
        int b;
        b    = m_ready.pop_front();
        m_rd = (m_rd + 1) % NB;
        if (m_fill < 0 && b == (m_last + 1) % NB) m_fill = b;
    endtask

    task automatic m_reset();
        for (int b = 0; b < NB; b++) m_q[b].delete();
        m_ready.delete();
        m_fill = 0;
        m_last = 0;
        m_rd   = 0;
        m_drop = 0;
    endtask

    task automatic send_word(input string tag);
        logic [DATA_W-1:0] d;
        logic [255:0]      exp_din;
        logic [NB-1:0]     exp_wr;
        int                eb;
        d  = {$urandom, $urandom};
        eb = m_fill;
        if (eb >= 0) m_q[eb].push_back(d);
        else m_drop++;
        datain_tdc = d;
        done       = 1'b1;
        tick();
        done    = 1'b0;
        exp_wr  = '0;
        exp_din = '0;
        if (eb >= 0) begin
            exp_wr[eb]                  = 1'b1;
            exp_din[eb*DATA_W +: DATA_W] = d;
        end
        chk({tag, "_wr"}, fifo_wr, exp_wr);
        chk({tag, "_din"}, fifo_din, exp_din);
        if (eb >= 0 && m_q[eb].size() == DEPTH) m_close();
        repeat ($urandom_range(2, 3)) tick();
    endtask

    task automatic do_read(input string tag, input bit burst, input int n);
        int                bank;
        int                rc0;
        logic [DATA_W-1:0] w;
        bank = m_rd;
        rc0  = rd_cnt[bank];
        got_q.delete();
        burst_mode = burst;
        read_in    = 1'b1;
        tick();
        tick();
        read_in = 1'b0;
        tick();
        tick();
        repeat (n + 3) tick();
        burst_mode = 1'b0;
        chk({tag, "_cnt"}, got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            w = m_q[bank].pop_front();
            chk($sformatf("%s_w%0d", tag, i), (i < got_q.size()) ? got_q[i] : '0, w);
        end
        chk({tag, "_rd"}, rd_cnt[bank] - rc0, n);
        if (m_q[bank].size() == 0) m_drained();
        repeat ($urandom_range(1, 3)) tick();
    endtask

    initial begin
        int k;
        reset      = 1'b1;
        done       = 1'b0;
        datain_tdc = '0;
        flush      = 1'b0;
        read_in    = 1'b0;
        burst_mode = 1'b0;
        m_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_fifo_wr", fifo_wr, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_sdk_valid", sdk_valid, 0);
        chk("rst_dataout", dataout_sdk, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_ready_cnt", ready_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);

        // bank0 fills to full and closes; 9th word lands in bank1
        repeat (DEPTH) send_word("fill0");
        chk("full0_ready_cnt", ready_cnt, m_ready.size());
        chk("full0_wr_bank", wr_bank, m_fill);
        send_word("word9");

        do_read("burst0", 1'b1, DEPTH);
        chk("burst0_rd_bank", rd_bank, m_rd);
        chk("burst0_ready_cnt", ready_cnt, m_ready.size());

        // bank1 completes; three single-word reads leave it draining
        repeat (DEPTH - 1) send_word("fill1");
        chk("full1_wr_bank", wr_bank, m_fill);
        do_read("single_a", 1'b0, 1);
        do_read("single_b", 1'b0, 1);
        do_read("single_c", 1'b0, 1);
        chk("single_ready_cnt", ready_cnt, 1);
        chk("single_rd_bank", rd_bank, 1);
        do_read("burst1_rest", 1'b1, DEPTH - 3);
        chk("burst1_rd_bank", rd_bank, m_rd);
        chk("burst1_ready_cnt", ready_cnt, 0);

        // every bank full with no reads: further words are dropped
        repeat (NB * DEPTH) send_word("ring");
        chk("ring_ready_cnt", ready_cnt, NB);
        repeat (5) send_word("drop");
        chk("drop_overflow", overflow, 1);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("drop_cnt5", drop_cnt, 5);

        // freeing the oldest bank hands it straight back to the writer
        do_read("burst2", 1'b1, DEPTH);
        tick();
        chk("refill_wr_bank", wr_bank, m_fill);
        chk("refill_ready_cnt", ready_cnt, m_ready.size());
        send_word("refill");

        do_read("burst3", 1'b1, DEPTH);
        do_read("burst0b", 1'b1, DEPTH);
        do_read("burst1b", 1'b1, DEPTH);
        chk("drained_ready_cnt", ready_cnt, 0);

        // flush closes a partial bank; flush on an empty bank is ignored
        repeat (2) send_word("part");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        m_close();
        tick();
        tick();
        chk("flush_wr_bank", wr_bank, m_fill);
        chk("flush_ready_cnt", ready_cnt, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        chk("flush_empty_wr_bank", wr_bank, m_fill);
        chk("flush_empty_ready_cnt", ready_cnt, 1);
        do_read("burst_part", 1'b1, 3);
        chk("part_rd_bank", rd_bank, m_rd);
        chk("part_ready_cnt", ready_cnt, 0);

        // reset in the middle of a burst
        repeat (DEPTH) send_word("fill3");
        got_q.delete();
        burst_mode = 1'b1;
        read_in    = 1'b1;
        k = 0;
        while (got_q.size() < 4 && k < 60) begin
            tick();
            k++;
        end
        chk("burst_reached4", got_q.size(), 4);
        read_in    = 1'b0;
        burst_mode = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_fifo_rd", fifo_rd, 0);
        chk("mid_rst_sdk_valid", sdk_valid, 0);
        chk("mid_rst_fifo_wr", fifo_wr, 0);
        chk("mid_rst_wr_bank", wr_bank, 0);
        chk("mid_rst_rd_bank", rd_bank, 0);
        chk("mid_rst_drop_cnt", drop_cnt, 0);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_ready_cnt", ready_cnt, 0);
        tick();
        reset = 1'b0;
        m_reset();
        tick();
        send_word("post_rst");
        chk("post_rst_wr_bank", wr_bank, m_fill);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
